// File: rtl/alu_pkg.sv
// Shared ALU opcode codes, RV32 opcode/funct encodings and the decoded-instruction
// record used by the issue decoder and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SEQ  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SGT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_NOT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SGTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SLA  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_MUL  = 4'd14;
  localparam logic [3:0] ALU_DIV  = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        branch;
    logic        br_invert;
    logic        rd_wen;
    logic        illegal;
  } dec_t;

  // Pipeline occupancy, encoded as {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } stage_state_e;

  function automatic dec_t dec_illegal();
    dec_t d;
    d = '0;
    d.illegal = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Purely combinational RV32I/M instruction to ALU-control decode.
module rv32_alu_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    logic legal;
    legal       = 1'b1;
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.rd_wen  = 1'b1;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  dec.alu_op = ALU_ADD;
            F3_SLL:  dec.alu_op = ALU_SLL;
            F3_SLT:  dec.alu_op = ALU_SLT;
            F3_SLTU: dec.alu_op = ALU_SLTU;
            F3_SR:   dec.alu_op = ALU_SRL;
            F3_OR:   dec.alu_op = ALU_OR;
            F3_AND:  dec.alu_op = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec.alu_op = ALU_SRA;
        end else if (ENABLE_M && funct7 == F7_MULDIV && funct3 == F3_ADD) begin
          dec.alu_op = ALU_MUL;
        end else if (ENABLE_M && funct7 == F7_MULDIV && funct3 == F3_DIV) begin
          dec.alu_op = ALU_DIV;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        case (funct3)
          F3_ADD:  dec.alu_op = ALU_ADD;
          F3_SLT:  dec.alu_op = ALU_SLT;
          F3_SLTU: dec.alu_op = ALU_SLTU;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          F3_SLL: begin
            dec.alu_op = ALU_SLL;
            legal      = (funct7 == F7_BASE);
          end
          F3_SR: begin
            dec.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal      = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.rd_wen = 1'b0;
        dec.imm    = imm_b;
        case (funct3)
          F3_BEQ:  dec.alu_op = ALU_SEQ;
          F3_BNE:  begin dec.alu_op = ALU_SEQ;  dec.br_invert = 1'b1; end
          F3_BLT:  dec.alu_op = ALU_SLT;
          F3_BGE:  begin dec.alu_op = ALU_SLT;  dec.br_invert = 1'b1; end
          F3_BLTU: dec.alu_op = ALU_SLTU;
          F3_BGEU: begin dec.alu_op = ALU_SLTU; dec.br_invert = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD:  begin dec.use_imm = 1'b1; dec.imm = imm_i; end
      OPC_STORE: begin dec.use_imm = 1'b1; dec.imm = imm_s; dec.rd_wen = 1'b0; end
      OPC_LUI:   begin dec.use_imm = 1'b1; dec.imm = imm_u; dec.rs1 = 5'd0; end
      OPC_AUIPC: begin dec.use_imm = 1'b1; dec.imm = imm_u; dec.use_pc = 1'b1; end
      OPC_JAL:   begin dec.use_imm = 1'b1; dec.imm = imm_j; dec.use_pc = 1'b1; end
      OPC_JALR:  begin dec.use_imm = 1'b1; dec.imm = imm_i; end
      default:   legal = 1'b0;
    endcase
    if (dec.rd == 5'd0) dec.rd_wen = 1'b0;
    if (!legal) dec = dec_illegal();
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// Registered decode stage: valid/ready in and out, with a one-entry skid buffer so
// in_ready comes straight from a flop while throughput stays at one per cycle.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_branch,
  output logic            out_br_invert,
  output logic            out_rd_wen,
  output logic            out_illegal
);

  dec_t            dec;
  dec_t            out_q, out_d, skid_q, skid_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, drain;
  stage_state_e    state;

  rv32_alu_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign state  = stage_state_e'({out_valid_q, skid_valid_q});
  assign accept = in_valid && !skid_valid_q && !flush;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_d       = dec;
            out_pc_d    = in_pc;
            out_valid_d = 1'b1;
          end
        end
        ST_FULL1: begin
          if (accept && drain) begin
            out_d    = dec;
            out_pc_d = in_pc;
          end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
          end else if (drain) begin
            out_valid_d = 1'b0;
          end
        end
        ST_FULL2: begin
          if (drain) begin
            out_d        = skid_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_alu_op    = out_q.alu_op;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_imm       = out_q.imm;
  assign out_use_imm   = out_q.use_imm;
  assign out_use_pc    = out_q.use_pc;
  assign out_branch    = out_q.branch;
  assign out_br_invert = out_q.br_invert;
  assign out_rd_wen    = out_q.rd_wen;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: decode vectors, skid back-pressure, flush and
// asynchronous reset, with a second instance built without the M extension.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst_n, flush, inValid, outReady;
  logic [31:0] inInstr, inPc;

  logic        inReady, outValid, useImm, usePc, branch, brInvert, rdWen, illegal;
  logic [3:0]  aluOp;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, outPc;

  logic        nmInReady, nmOutValid, nmUseImm, nmUsePc, nmBranch, nmBrInvert, nmRdWen, nmIllegal;
  logic [3:0]  nmAluOp;
  logic [4:0]  nmRs1, nmRs2, nmRd;
  logic [31:0] nmImm, nmOutPc;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  alu_issue_decoder #(.PC_W(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
    .out_valid(outValid), .out_ready(outReady),
    .out_alu_op(aluOp), .out_rs1(rs1), .out_rs2(rs2), .out_rd(rd), .out_imm(imm),
    .out_pc(outPc), .out_use_imm(useImm), .out_use_pc(usePc), .out_branch(branch),
    .out_br_invert(brInvert), .out_rd_wen(rdWen), .out_illegal(illegal)
  );

  alu_issue_decoder #(.PC_W(32), .ENABLE_M(1'b0)) dutNoM (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(nmInReady), .in_instr(inInstr), .in_pc(inPc),
    .out_valid(nmOutValid), .out_ready(outReady),
    .out_alu_op(nmAluOp), .out_rs1(nmRs1), .out_rs2(nmRs2), .out_rd(nmRd), .out_imm(nmImm),
    .out_pc(nmOutPc), .out_use_imm(nmUseImm), .out_use_pc(nmUsePc), .out_branch(nmBranch),
    .out_br_invert(nmBrInvert), .out_rd_wen(nmRdWen), .out_illegal(nmIllegal)
  );

  // Every comparison in the bench goes through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic ready);
    inInstr  = instr;
    inPc     = pc;
    inValid  = valid;
    outReady = ready;
  endtask

  // Offer one word with the output free-flowing; returns at the negedge where it is visible.
  task automatic decodeOne(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    applyStimulus(instr, pc, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_alu_op", aluOp, 0);
    checkOutput("rst_imm", imm, 0);
    checkOutput("rst_pc", outPc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", inReady, 1);

    decodeOne(32'h002081B3, 32'h1000);
    checkOutput("add_valid", outValid, 1);
    checkOutput("add_op", aluOp, 0);
    checkOutput("add_rs1", rs1, 1);
    checkOutput("add_rs2", rs2, 2);
    checkOutput("add_rd", rd, 3);
    checkOutput("add_rd_wen", rdWen, 1);
    checkOutput("add_illegal", illegal, 0);
    checkOutput("add_use_imm", useImm, 0);
    checkOutput("add_pc", outPc, 32'h1000);

    decodeOne(32'h40208133, 32'h1004);
    checkOutput("sub_op", aluOp, 1);
    checkOutput("sub_rd", rd, 2);

    decodeOne(32'h022081B3, 32'h1008);
    checkOutput("mul_op", aluOp, 14);
    checkOutput("mul_illegal", illegal, 0);
    checkOutput("mul_nom_illegal", nmIllegal, 1);
    checkOutput("mul_nom_op", nmAluOp, 0);
    checkOutput("mul_nom_valid", nmOutValid, 1);

    decodeOne(32'hFFF00093, 32'h100C);
    checkOutput("addi_op", aluOp, 0);
    checkOutput("addi_imm", imm, 32'hFFFFFFFF);
    checkOutput("addi_use_imm", useImm, 1);
    checkOutput("addi_rd_wen", rdWen, 1);

    decodeOne(32'h0020C1B3, 32'h1010);
    checkOutput("xor_illegal", illegal, 1);
    checkOutput("xor_op", aluOp, 0);
    checkOutput("xor_rd_wen", rdWen, 0);
    checkOutput("xor_valid", outValid, 1);

    decodeOne(32'h00209463, 32'h1014);
    checkOutput("bne_op", aluOp, 2);
    checkOutput("bne_branch", branch, 1);
    checkOutput("bne_invert", brInvert, 1);
    checkOutput("bne_imm", imm, 8);
    checkOutput("bne_rd_wen", rdWen, 0);

    decodeOne(32'h123452B7, 32'h1018);
    checkOutput("lui_imm", imm, 32'h12345000);
    checkOutput("lui_rs1", rs1, 0);
    checkOutput("lui_use_imm", useImm, 1);

    decodeOne(32'h010000EF, 32'h101C);
    checkOutput("jal_imm", imm, 16);
    checkOutput("jal_use_pc", usePc, 1);
    checkOutput("jal_rd_wen", rdWen, 1);

    decodeOne(32'h00000013, 32'h1020);
    checkOutput("nop_rd_wen", rdWen, 0);
    checkOutput("nop_illegal", illegal, 0);

    // Back-pressure: A, B, C offered with the consumer stalled for three cycles.
    @(negedge clk);
    applyStimulus(32'h002081B3, 32'h2000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_a_in_ready", inReady, 1);
    checkOutput("stall_a_pc", outPc, 32'h2000);
    applyStimulus(32'h40208133, 32'h2004, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_b_in_ready", inReady, 0);
    checkOutput("stall_hold_pc", outPc, 32'h2000);
    applyStimulus(32'h00209463, 32'h2008, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_c_held", inReady, 0);
    checkOutput("stall_hold_op", aluOp, 0);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("order_b_pc", outPc, 32'h2004);
    checkOutput("order_b_op", aluOp, 1);
    checkOutput("order_b_in_ready", inReady, 1);
    @(negedge clk);
    checkOutput("order_c_pc", outPc, 32'h2008);
    checkOutput("order_c_op", aluOp, 2);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("order_drained", outValid, 0);

    // Fill to FULL2, then flush while a new word is being offered.
    applyStimulus(32'h002081B3, 32'h3000, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h40208133, 32'h3004, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("full2_in_ready", inReady, 0);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", outValid, 0);
    checkOutput("flush_in_ready", inReady, 1);
    flush = 1'b1;
    applyStimulus(32'h00209463, 32'h3008, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_blocks_accept", outValid, 0);
    flush = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a held transfer.
    applyStimulus(32'hFFF00093, 32'h4000, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", outValid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", outValid, 0);
    checkOutput("async_rst_imm", imm, 0);
    checkOutput("async_rst_pc", outPc, 0);
    checkOutput("async_rst_use_imm", useImm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", inReady, 1);
    checkOutput("post_rst_valid", outValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
